// File: rtl/ofdm_cp_scheduler_if.sv
// ofdm_cp_scheduler_if: sample-stream handshakes between IFFT, CP scheduler and DAC framing
interface ofdm_cp_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_sof;
  logic out_eof;
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eof
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/ofdm_cp_scheduler.sv
// ofdm_cp_scheduler: buffers one OFDM symbol, then emits its last CP_LEN samples followed by the whole symbol
module ofdm_cp_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int N_FFT      = 8,
  parameter int CP_LEN     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ofdm_cp_scheduler_if.slave     s,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   sym_count
);
  localparam int IW = (N_FFT > 1) ? $clog2(N_FFT) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_FFT - 1);
  // Only meaningful when CP_LEN > 0; the CP_LEN == 0 path never reads it
  localparam logic [IW-1:0] CP_START = IW'(N_FFT - CP_LEN);
  typedef enum logic [1:0] {FILL, EMIT_CP, EMIT_BODY} state_t;
  state_t state, state_n;
  logic [IW-1:0] wr_idx, wr_n, rd_idx, rd_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic signed [DATA_WIDTH-1:0] mem [N_FFT];
  logic in_fire, out_fire;
  assign in_fire  = s.in_valid & s.in_ready;
  assign out_fire = s.out_valid & s.out_ready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FILL;
      wr_idx    <= '0;
      rd_idx    <= '0;
      sym_count <= '0;
    end else begin
      state     <= state_n;
      wr_idx    <= wr_n;
      rd_idx    <= rd_n;
      sym_count <= cnt_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && !flush && in_fire) mem[wr_idx] <= s.in_data;
  end
  always_comb begin
    state_n = state;
    wr_n    = wr_idx;
    rd_n    = rd_idx;
    cnt_n   = sym_count;
    if (flush) begin
      state_n = FILL;
      wr_n    = '0;
      rd_n    = '0;
    end else if (state == FILL && in_fire) begin
      wr_n = (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
      if (wr_idx == LAST) begin
        if (CP_LEN == 0) begin
          rd_n    = '0;
          state_n = EMIT_BODY;
        end else begin
          rd_n    = CP_START;
          state_n = EMIT_CP;
        end
      end
    end else if (state == EMIT_CP && out_fire) begin
      rd_n = (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
      if (rd_idx == LAST) state_n = EMIT_BODY;
    end else if (state == EMIT_BODY && out_fire) begin
      rd_n = (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
      if (rd_idx == LAST) begin
        state_n = FILL;
        cnt_n   = sym_count + 1'b1;
      end
    end
  end
  assign s.in_ready  = (state == FILL);
  assign s.out_valid = (state != FILL);
  assign s.out_data  = s.out_valid ? mem[rd_idx] : '0;
  assign s.out_sof   = (state == EMIT_CP && rd_idx == CP_START) ||
                       (state == EMIT_BODY && CP_LEN == 0 && rd_idx == '0);
  assign s.out_eof   = (state == EMIT_BODY && rd_idx == LAST);
  assign busy        = (state != FILL) || (wr_idx != '0);
endmodule

// File: tb/tb_ofdm_cp_scheduler.sv
// tb_ofdm_cp_scheduler: queue-based symbol model checked every cycle, plus directed literal scenarios
module tb_ofdm_cp_scheduler;
  localparam int DW = 32, N = 8, CP = 2, CW = 16;
  typedef struct packed {logic [DW-1:0] d; logic sof; logic eof;} smp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 0, flush = 0, chk_en = 0;
  logic busy, busy1;
  logic [CW-1:0] sym, sym1;
  ofdm_cp_scheduler_if #(.DATA_WIDTH(DW)) b ();
  ofdm_cp_scheduler_if #(.DATA_WIDTH(DW)) b1 ();
  ofdm_cp_scheduler #(.DATA_WIDTH(DW), .N_FFT(N), .CP_LEN(CP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .s(b.slave), .busy(busy), .sym_count(sym));
  ofdm_cp_scheduler #(.DATA_WIDTH(DW), .N_FFT(N), .CP_LEN(0), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst(rst), .flush(1'b0), .s(b1.slave), .busy(busy1), .sym_count(sym1));
  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Model: gather N samples, then a queue of N+CP tagged outputs drained by out_ready
  logic [DW-1:0] fillq[$];
  smp_t outq[$];
  logic [DW-1:0] log_q[$];
  logic [CW-1:0] m_sym;
  smp_t h;
  always @(posedge clk) begin
    if (!rst) begin
      fillq.delete(); outq.delete(); m_sym = '0;
    end else if (flush) begin
      fillq.delete(); outq.delete();
    end else if (outq.size() == 0) begin
      if (b.in_valid) begin
        fillq.push_back(b.in_data);
        if (fillq.size() == N) begin
          for (int i = N - CP; i < N; i++) outq.push_back('{fillq[i], 1'(i == N - CP), 1'b0});
          for (int i = 0; i < N; i++) outq.push_back('{fillq[i], 1'(CP == 0 && i == 0), 1'(i == N - 1)});
          fillq.delete();
        end
      end
    end else if (b.out_ready) begin
      log_q.push_back(outq[0].d);
      if (outq[0].eof) m_sym = m_sym + 1'b1;
      void'(outq.pop_front());
    end
  end
  always @(negedge clk) if (chk_en) begin
    h = (outq.size() != 0) ? outq[0] : '0;
    check("in_ready", 32'(b.in_ready), 32'(outq.size() == 0));
    check("out_valid", 32'(b.out_valid), 32'(outq.size() != 0));
    check("out_data", b.out_data, h.d);
    check("out_sof", 32'(b.out_sof), 32'(h.sof));
    check("out_eof", 32'(b.out_eof), 32'(h.eof));
    check("busy", 32'(busy), 32'(outq.size() != 0 || fillq.size() != 0));
    check("sym_count", 32'(sym), 32'(m_sym));
  end
  logic [DW-1:0] stim[$];
  int exp1[10] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
  task automatic tick(); @(negedge clk); #1; endtask
  task automatic do_reset();
    rst = 0; flush = 0;
    b.in_valid = 0; b.in_data = '0; b.out_ready = 0;
    b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 0;
    tick(); tick();
    rst = 1; chk_en = 1;
    log_q.delete(); stim.delete();
  endtask
  task automatic mk(input int base);
    for (int i = 0; i < N; i++) stim.push_back(DW'(base + i));
  endtask
  // mode 0: out_ready high, 1: toggling, 2: random gaps both sides
  task automatic feed(input int mode, input int stop_in, input int stop_out);
    logic [DW-1:0] p[$];
    int t = 0, n_in = 0;
    p = stim;
    while ((p.size() != 0 || outq.size() != 0 || fillq.size() != 0) &&
           n_in < stop_in && log_q.size() < stop_out && t < 400) begin
      b.in_valid  = (p.size() != 0) && (mode != 2 || $urandom_range(0, 3) != 0);
      b.in_data   = (p.size() != 0) ? p[0] : DW'($urandom);
      b.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(t % 2 == 0) : 1'($urandom_range(0, 1));
      if (b.in_valid && b.in_ready) begin void'(p.pop_front()); n_in++; end
      tick(); t++;
    end
    b.in_valid = 0;
    stim.delete();
    check("feed_in_time", 32'(t < 400), 32'd1);
  endtask
  task automatic check_sym(input string name, input int off, input int base);
    for (int k = 0; k < 10; k++)
      check(name, (off + k < log_q.size()) ? log_q[off + k] : 32'hdead_beef, DW'(base + exp1[k]));
  endtask
  task automatic check_idle(input string name);
    check({name, "_valid"}, 32'(b.out_valid), 32'd0);
    check({name, "_ready"}, 32'(b.in_ready), 32'd1);
    check({name, "_sof"}, 32'(b.out_sof), 32'd0);
    check({name, "_data"}, b.out_data, 32'd0);
  endtask
  initial begin
    do_reset();
    check_idle("reset");
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sym", 32'(sym), 32'd0);
    mk(0); feed(0, 99, 99);
    check("t1_len", log_q.size(), 32'd10);
    check_sym("t1_out", 0, 0);
    check("t1_sym", 32'(sym), 32'd1);
    do_reset(); mk(0); feed(1, 99, 99);
    check("t2_len", log_q.size(), 32'd10);
    check_sym("t2_out", 0, 0);
    do_reset(); mk(100); mk(200); feed(0, 99, 99);
    check("t3_len", log_q.size(), 32'd20);
    check_sym("t3_sym0", 0, 100);
    check_sym("t3_sym1", 10, 200);
    check("t3_sym", 32'(sym), 32'd2);
    do_reset(); mk(0); feed(0, 99, 4);
    flush = 1; tick(); flush = 0;
    check_idle("t4_flush");
    check("t4_sym", 32'(sym), 32'd0);
    log_q.delete(); mk(0); feed(0, 99, 99);
    check("t4_len", log_q.size(), 32'd10);
    check_sym("t4_out", 0, 0);
    check("t4_sym_after", 32'(sym), 32'd1);
    do_reset(); mk(50); feed(0, 5, 99);
    rst = 0; tick(); rst = 1;
    check_idle("t5a_rst");
    check("t5a_busy", 32'(busy), 32'd0);
    mk(0); feed(0, 99, 99);
    check("t5a_len", log_q.size(), 32'd10);
    check_sym("t5a_out", 0, 0);
    do_reset(); mk(0); mk(10); feed(0, 99, 11);
    check("t5b_pre_sym", 32'(sym), 32'd1);
    rst = 0; tick(); rst = 1; log_q.delete();
    check_idle("t5b_rst");
    check("t5b_sym", 32'(sym), 32'd0);
    mk(20); feed(0, 99, 99);
    check_sym("t5b_out", 0, 20);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      b.in_valid  = 1'($urandom_range(0, 3) != 0);
      b.in_data   = DW'($urandom);
      b.out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 59) == 0);
      rst   = 1'($urandom_range(0, 399) != 0);
      tick();
    end
    flush = 0; rst = 1;
    for (int r = 0; r < 6; r++) begin
      log_q.delete(); mk(int'($urandom_range(0, 1000)));
      feed(2, 99, 99);
    end
    do_reset();
    b1.out_ready = 1;
    begin
      int i = 0, k = 0;
      for (int t = 0; t < 40; t++) begin
        if (b1.out_valid) begin
          check("t6_data", b1.out_data, DW'(k - 3));
          check("t6_sof", 32'(b1.out_sof), 32'(k == 0));
          check("t6_eof", 32'(b1.out_eof), 32'(k == 7));
          k++;
        end
        b1.in_valid = 1'(i < 8);
        b1.in_data  = DW'(i - 3);
        if (b1.in_valid && b1.in_ready) i++;
        tick();
      end
      check("t6_count", k, 32'd8);
      check("t6_sym", 32'(sym1), 32'd1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
